// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types, constants and bit-timing helper for the
//               multi-byte UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    typedef enum logic [0:0] {
        WAIT_FIRST = 1'b0,
        COLLECT    = 1'b1
    } frame_state_t;

    // Rounded clocks per bit: round(1e9 / (period_ns * baud)).
    function automatic int clks_per_bit(input int sys_clk_period, input int baud_rate);
        longint denom;
        denom = longint'(sys_clk_period) * longint'(baud_rate);
        return int'((longint'(1_000_000_000) + denom / 2) / denom);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_byte
// Description : Single-byte UART receiver: input synchroniser, baud counter
//               and byte FSM. UART_RX_PARITY_EN adds an even-parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int SYS_CLK_PERIOD = 20,
    parameter int BAUD_RATE      = 1152000
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       SDATA_I,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o,
    output logic       idle_o
);

    localparam int c_clks_per_bit = clks_per_bit(SYS_CLK_PERIOD, BAUD_RATE);
    localparam int c_baud_w       = (c_clks_per_bit > 1) ? $clog2(c_clks_per_bit) : 1;
    localparam logic [c_baud_w-1:0] c_half_last = c_baud_w'(c_clks_per_bit / 2 - 1);
    localparam logic [c_baud_w-1:0] c_bit_last  = c_baud_w'(c_clks_per_bit - 1);
    localparam logic [2:0] c_last_data_bit      = 3'(UART_DATA_BITS - 1);

    logic                      r_sync1;
    logic                      r_rxd;
    logic                      r_rxd_prev;
    logic [1:0]                r_sync_fill;
    rx_state_t                 r_state;
    logic [c_baud_w-1:0]       r_baud_cnt;
    logic [2:0]                r_bit_cnt;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_valid;
    logic                      r_ferr;
    logic                      w_bit_end;

    assign w_bit_end = (r_baud_cnt == c_bit_last);

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_sync1     <= 1'b1;
            r_rxd       <= 1'b1;
            r_rxd_prev  <= 1'b0;
            r_sync_fill <= 2'b00;
            r_state     <= IDLE;
            r_baud_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_valid     <= 1'b0;
            r_ferr      <= 1'b0;
        end else begin
            r_sync1     <= SDATA_I;
            r_rxd       <= r_sync1;
            r_sync_fill <= {r_sync_fill[0], 1'b1};
            // The reset value of the synchroniser is not a real line sample,
            // so a line held low across reset must rise before it can fall.
            r_rxd_prev  <= r_rxd & r_sync_fill[1];
            r_valid     <= 1'b0;
            r_ferr      <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (r_rxd_prev && !r_rxd) begin
                        r_state    <= START;
                        r_baud_cnt <= '0;
                    end
                end
                START: begin
                    if (r_baud_cnt == c_half_last) begin
                        r_baud_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_state    <= r_rxd ? IDLE : DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_shift    <= {r_rxd, r_shift[UART_DATA_BITS-1:1]};
                        r_bit_cnt  <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == c_last_data_bit) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (r_rxd != ^r_shift) begin
                            r_ferr  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_state <= STOP;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_valid    <= r_rxd;
                        r_ferr     <= !r_rxd;
                        r_state    <= IDLE;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign byte_o       = r_shift;
    assign byte_valid_o = r_valid;
    assign frame_err_o  = r_ferr;
    assign idle_o       = (r_state == IDLE);

endmodule
`default_nettype wire

// File: rtl/uart_rx_wrapper.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_wrapper
// Description : Multi-byte UART receiver; assembles BYTE_NUM bytes into one
//               word with inter-byte timeout. Option: UART_RX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_wrapper
    import uart_pkg::*;
#(
    parameter int SYS_CLK_PERIOD  = 20,
    parameter int BAUD_RATE       = 1152000,
    parameter int BYTE_NUM        = 8,
    parameter int TIMEOUT_BIT_NUM = 20
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic                  SDATA_I,
    output logic [BYTE_NUM*8-1:0] DATA_O,
    output logic                  DONE_O,
    output logic                  ERR_O,
    output logic                  BUSY_O
);

    localparam int c_clks_per_bit = clks_per_bit(SYS_CLK_PERIOD, BAUD_RATE);
    localparam int c_frame_w      = BYTE_NUM * UART_DATA_BITS;
    localparam int c_timeout_clks = TIMEOUT_BIT_NUM * c_clks_per_bit;
    localparam int c_gap_w        = $clog2(c_timeout_clks + 1);
    localparam int c_cnt_w        = $clog2(BYTE_NUM + 1);
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(c_timeout_clks - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(BYTE_NUM - 1);

    logic [UART_DATA_BITS-1:0] w_byte;
    logic                      w_valid;
    logic                      w_ferr;
    logic                      w_idle;
    logic                      w_timeout;
    logic [c_frame_w-1:0]      w_shadow_next;

    frame_state_t              r_state;
    logic [c_cnt_w-1:0]        r_byte_cnt;
    logic [c_gap_w-1:0]        r_gap;
    logic [c_frame_w-1:0]      r_data;
    logic                      r_done;
    logic                      r_err;
    logic                      r_busy;

    uart_rx_byte #(
        .SYS_CLK_PERIOD (SYS_CLK_PERIOD),
        .BAUD_RATE      (BAUD_RATE)
    ) u_byte (
        .CLK_I        (CLK_I),
        .RST_I        (RST_I),
        .SDATA_I      (SDATA_I),
        .byte_o       (w_byte),
        .byte_valid_o (w_valid),
        .frame_err_o  (w_ferr),
        .idle_o       (w_idle)
    );

    assign w_timeout = (r_state == COLLECT) && w_idle && (r_gap == c_gap_last);

    // Bytes enter from the LS side so the first byte lands in the MS byte.
    generate
        if (BYTE_NUM == 1) begin : g_single
            assign w_shadow_next = w_byte;
        end else begin : g_multi
            logic [c_frame_w-UART_DATA_BITS-1:0] r_shadow;

            always_ff @(posedge CLK_I or posedge RST_I) begin
                if (RST_I) begin
                    r_shadow <= '0;
                end else if (w_ferr) begin
                    r_shadow <= '0;
                end else if (w_valid) begin
                    r_shadow <= w_shadow_next[c_frame_w-UART_DATA_BITS-1:0];
                end else if (w_timeout) begin
                    r_shadow <= '0;
                end
            end

            assign w_shadow_next = {r_shadow, w_byte};
        end
    endgenerate

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_state    <= WAIT_FIRST;
            r_byte_cnt <= '0;
            r_gap      <= '0;
            r_data     <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_ferr) begin
                r_err      <= 1'b1;
                r_byte_cnt <= '0;
                r_gap      <= '0;
                r_busy     <= 1'b0;
                r_state    <= WAIT_FIRST;
            end else if (w_valid) begin
                r_gap <= '0;
                if (r_byte_cnt == c_cnt_last) begin
                    r_data     <= w_shadow_next;
                    r_done     <= 1'b1;
                    r_byte_cnt <= '0;
                    r_busy     <= 1'b0;
                    r_state    <= WAIT_FIRST;
                end else begin
                    r_byte_cnt <= r_byte_cnt + 1'b1;
                    r_busy     <= 1'b1;
                    r_state    <= COLLECT;
                end
            end else if (r_state == COLLECT) begin
                if (w_timeout) begin
                    r_err      <= 1'b1;
                    r_byte_cnt <= '0;
                    r_gap      <= '0;
                    r_busy     <= 1'b0;
                    r_state    <= WAIT_FIRST;
                end else if (!w_idle) begin
                    r_gap <= '0;
                end else begin
                    r_gap <= r_gap + 1'b1;
                end
            end else begin
                r_busy <= !w_idle;
            end
        end
    end

    assign DATA_O = r_data;
    assign DONE_O = r_done;
    assign ERR_O  = r_err;
    assign BUSY_O = r_busy;

endmodule
`default_nettype wire
